// File: rtl/motion_pkg.sv
// Shared definitions for the motion sweep scheduler: FSM states and channel word indices.
package motion_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_ACK,
        RD_COUNT,
        RD_TURNS,
        RD_VEL,
        NEXT,
        COMMIT
    } state_t;

    localparam logic [1:0] WORD_COUNT = 2'd0;
    localparam logic [1:0] WORD_TURNS = 2'd1;
    localparam logic [1:0] WORD_VEL   = 2'd2;
    localparam logic [1:0] WORD_SEQ   = 2'd3;

endpackage

// File: rtl/motion_if.sv
// Channel snapshot bus and host read port shared by the scheduler and its environment.
interface motion_if #(
    parameter int NUM_CH = 4
);
    localparam int CW = $clog2(NUM_CH);

    // snap_req stays high until snap_ack is sampled high on a rising edge (or the wait
    // times out); ch_data is combinational on ch_sel/word_sel. rd_req is a one-cycle
    // strobe; rd_ack pulses one cycle later and qualifies rd_data for that cycle only.
    logic [CW-1:0] ch_sel;
    logic [1:0]    word_sel;
    logic          snap_req;
    logic          snap_ack;
    logic [31:0]   ch_data;
    logic          rd_req;
    logic [CW+1:0] rd_addr;
    logic [31:0]   rd_data;
    logic          rd_ack;

    modport master (
        output ch_sel, word_sel, snap_req, rd_data, rd_ack,
        input  snap_ack, ch_data, rd_req, rd_addr
    );

    modport slave (
        input  ch_sel, word_sel, snap_req, rd_data, rd_ack,
        output snap_ack, ch_data, rd_req, rd_addr
    );

endinterface

// File: rtl/motion_period_timer.sv
// Free-running sweep interval timer; held at zero while disabled, one-cycle tick on wrap.
module motion_period_timer #(
    parameter int PERIOD = 10000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);
    localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [TW-1:0] LAST = TW'(PERIOD - 1);

    logic [TW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (!enable || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = enable && (count == LAST);

endmodule

// File: rtl/motion_scheduler.sv
// Periodically snapshots every motion channel into a back bank, then commits it atomically
// to a host-readable front bank with a sequence number.
module motion_scheduler
    import motion_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int PERIOD  = 10000,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    motion_if.master          bus,
    input  logic              err_clr,
    output logic              sweep_done,
    output logic [15:0]       seq_num,
    output logic [NUM_CH-1:0] timeout_err,
    output logic              overrun,
    output state_t            dbg_state
);
    localparam int CW = $clog2(NUM_CH);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_CH  = CW'(NUM_CH - 1);
    localparam logic [WW-1:0] LAST_WAIT = WW'(TIMEOUT - 1);

    state_t            state, next_state;
    logic              tick;
    logic              timed_out;
    logic [WW-1:0]     wait_cnt;
    logic [NUM_CH-1:0] to_set;
    logic [CW-1:0]     rd_ch;
    logic [1:0]        rd_word;
    logic [31:0]       back_bank  [NUM_CH][3];
    logic [31:0]       front_bank [NUM_CH][3];

    motion_period_timer #(.PERIOD(PERIOD)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tick   (tick)
    );

    assign timed_out = (state == WAIT_ACK) && !bus.snap_ack && (wait_cnt == LAST_WAIT);
    assign {rd_ch, rd_word} = bus.rd_addr;
    assign dbg_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state   = state;
        bus.snap_req = 1'b0;
        bus.word_sel = WORD_COUNT;
        case (state)
            IDLE:     if (tick) next_state = REQ;
            REQ: begin
                bus.snap_req = 1'b1;
                next_state   = WAIT_ACK;
            end
            WAIT_ACK: begin
                bus.snap_req = 1'b1;
                if (bus.snap_ack)   next_state = RD_COUNT;
                else if (timed_out) next_state = NEXT;
            end
            RD_COUNT: begin
                bus.word_sel = WORD_COUNT;
                next_state   = RD_TURNS;
            end
            RD_TURNS: begin
                bus.word_sel = WORD_TURNS;
                next_state   = RD_VEL;
            end
            RD_VEL: begin
                bus.word_sel = WORD_VEL;
                next_state   = NEXT;
            end
            NEXT:     next_state = (bus.ch_sel == LAST_CH) ? COMMIT : REQ;
            COMMIT:   next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_comb begin
        to_set = '0;
        if (timed_out) to_set[bus.ch_sel] = 1'b1;
    end

    // A timed-out channel never reaches the RD_* states, so its back-bank words survive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.ch_sel  <= '0;
            wait_cnt    <= '0;
            sweep_done  <= 1'b0;
            seq_num     <= '0;
            timeout_err <= '0;
            overrun     <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                for (int w = 0; w < 3; w++) begin
                    back_bank[c][w]  <= '0;
                    front_bank[c][w] <= '0;
                end
            end
        end else begin
            sweep_done  <= (state == COMMIT);
            wait_cnt    <= (state == WAIT_ACK) ? wait_cnt + 1'b1 : '0;
            overrun     <= (tick && state != IDLE) || (overrun && !err_clr);
            timeout_err <= to_set | (timeout_err & ~{NUM_CH{err_clr}});
            case (state)
                RD_COUNT: back_bank[bus.ch_sel][0] <= bus.ch_data;
                RD_TURNS: back_bank[bus.ch_sel][1] <= bus.ch_data;
                RD_VEL:   back_bank[bus.ch_sel][2] <= bus.ch_data;
                NEXT:     if (bus.ch_sel != LAST_CH) bus.ch_sel <= bus.ch_sel + 1'b1;
                COMMIT: begin
                    front_bank <= back_bank;
                    seq_num    <= seq_num + 16'd1;
                    bus.ch_sel <= '0;
                end
                default: ;
            endcase
        end
    end

    // Front bank is sampled in the rd_req cycle, so a read during COMMIT sees the old sweep.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rd_ack  <= 1'b0;
            bus.rd_data <= '0;
        end else begin
            bus.rd_ack <= bus.rd_req;
            if (bus.rd_req) begin
                case (rd_word)
                    WORD_COUNT: bus.rd_data <= front_bank[rd_ch][0];
                    WORD_TURNS: bus.rd_data <= front_bank[rd_ch][1];
                    WORD_VEL:   bus.rd_data <= front_bank[rd_ch][2];
                    default:    bus.rd_data <= {16'h0, seq_num};
                endcase
            end
        end
    end

endmodule

// File: tb/tb_motion_scheduler.sv
// Randomized bench for motion_scheduler: channel responder, sweep-level reference model, reports.
module tb_motion_scheduler;
    import motion_pkg::*;

    localparam int NUM_CH  = 2;
    localparam int PERIOD  = 20;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              err_clr;
    logic              sweep_done;
    logic [15:0]       seq_num;
    logic [NUM_CH-1:0] timeout_err;
    logic              overrun;
    state_t            dbg_state;

    motion_if #(.NUM_CH(NUM_CH)) bus ();

    motion_scheduler #(.NUM_CH(NUM_CH), .PERIOD(PERIOD), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .bus         (bus),
        .err_clr     (err_clr),
        .sweep_done  (sweep_done),
        .seq_num     (seq_num),
        .timeout_err (timeout_err),
        .overrun     (overrun),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- channel model ----------------
    logic [31:0] ch_words [NUM_CH][3];
    int          ack_delay = 2;
    bit          never_ack [NUM_CH];

    always_comb begin
        bus.ch_data = 32'h0;
        case (bus.word_sel)
            2'd0:    bus.ch_data = ch_words[bus.ch_sel][0];
            2'd1:    bus.ch_data = ch_words[bus.ch_sel][1];
            2'd2:    bus.ch_data = ch_words[bus.ch_sel][2];
            default: bus.ch_data = 32'h0;
        endcase
    end

    // Ack arrives ack_delay cycles after the request cycle; random noise while not requested.
    initial begin : channel_model
        int age;
        age = 0;
        bus.snap_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.snap_req) age++;
            else              age = 0;
            if (bus.snap_req) bus.snap_ack = !never_ack[bus.ch_sel] && (age > ack_delay);
            else              bus.snap_ack = ($urandom_range(0, 3) == 0);
        end
    end

    int done_cnt = 0;
    always @(negedge clk) if (sweep_done) done_cnt++;

    // ---------------- reference model ----------------
    logic [31:0]       m_front [NUM_CH][3];
    logic [15:0]       m_seq;
    logic [NUM_CH-1:0] m_to;
    logic              m_ovr;
    int                exp_done;

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++)
            for (int w = 0; w < 3; w++) m_front[c][w] = 32'h0;
        m_seq = 16'h0;
        m_to  = '0;
        m_ovr = 1'b0;
    endtask

    task automatic model_commit();
        for (int c = 0; c < NUM_CH; c++) begin
            if (never_ack[c]) m_to[c] = 1'b1;
            else for (int w = 0; w < 3; w++) m_front[c][w] = ch_words[c][w];
        end
        m_seq = m_seq + 16'd1;
        exp_done++;
    endtask

    function automatic logic [31:0] model_read(input int c, input int w);
        if (w == 3) return {16'h0, m_seq};
        return m_front[c][w];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_read(input int c, input int w, output logic [31:0] data, output logic ack);
        bus.rd_req  = 1'b1;
        bus.rd_addr = 3'((c << 2) | w);
        @(negedge clk);
        bus.rd_req = 1'b0;
        data = bus.rd_data;
        ack  = bus.rd_ack;
    endtask

    task automatic verify_reads(input string tag);
        logic [31:0] d;
        logic        a;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int w = 0; w < 4; w++) begin
                do_read(c, w, d, a);
                check($sformatf("%s_ack_c%0dw%0d", tag, c, w), 32'(a), 32'd1);
                check($sformatf("%s_data_c%0dw%0d", tag, c, w), d, model_read(c, w));
            end
        end
        @(negedge clk);
        check({tag, "_ack_pulse"}, 32'(bus.rd_ack), 32'd0);
        check({tag, "_seq"}, 32'(seq_num), 32'(m_seq));
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'(exp_done));
        check({tag, "_timeout_err"}, 32'(timeout_err), 32'(m_to));
        check({tag, "_overrun"}, 32'(overrun), 32'(m_ovr));
    endtask

    task automatic scramble_words();
        for (int c = 0; c < NUM_CH; c++)
            for (int w = 0; w < 3; w++) ch_words[c][w] = $urandom();
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_to  = '0;
        m_ovr = 1'b0;
        check("err_clr_overrun", 32'(overrun), 32'd0);
        check("err_clr_timeout", 32'(timeout_err), 32'd0);
    endtask

    // One sweep: enable drops once the sweep has started unless hold_en; optional read
    // coincident with COMMIT; optional err_clr aligned with a channel-1 timeout.
    task automatic run_sweep(input bit hold_en, input int probe, input bit clr_on_set,
                             output int ch1_req_cycles, output int ch0_starts);
        int          cyc;
        bit          done;
        bit          prev_req;
        logic [31:0] exp_p;
        logic [31:0] d;
        logic        a;
        cyc = 0; done = 0; prev_req = 0;
        ch1_req_cycles = 0; ch0_starts = 0;
        enable = 1'b1;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            err_clr = 1'b0;
            if (bus.snap_req && !prev_req && bus.ch_sel == 1'b0) ch0_starts++;
            if (bus.snap_req && bus.ch_sel == 1'b1) ch1_req_cycles++;
            prev_req = bus.snap_req;
            if (bus.snap_req && !hold_en) enable = 1'b0;
            if (clr_on_set && ch1_req_cycles == TIMEOUT + 1 && bus.snap_req) err_clr = 1'b1;
            if (dbg_state == COMMIT && probe >= 0) begin
                exp_p = model_read(probe >> 2, probe & 3);
                do_read(probe >> 2, probe & 3, d, a);
                check("coinc_ack", 32'(a), 32'd1);
                check("coinc_data", d, exp_p);
                check("coinc_done", 32'(sweep_done), 32'd1);
                done = 1;
            end else if (sweep_done) begin
                done = 1;
            end
        end
        check("sweep_completes", 32'(done), 32'd1);
        enable  = 1'b0;
        err_clr = 1'b0;
        model_commit();
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int r1, r0;
        bit found;
        reset = 1'b1; enable = 1'b0; err_clr = 1'b0;
        bus.rd_req = 1'b0; bus.rd_addr = '0;
        exp_done = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            never_ack[c] = 1'b0;
            for (int w = 0; w < 3; w++) ch_words[c][w] = 32'(c * 16 + w);
        end
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        check("rst_seq", 32'(seq_num), 32'd0);
        check("rst_snap_req", 32'(bus.snap_req), 32'd0);
        check("rst_ch_sel", 32'(bus.ch_sel), 32'd0);
        check("rst_word_sel", 32'(bus.word_sel), 32'd0);
        check("rst_rd_ack", 32'(bus.rd_ack), 32'd0);
        check("rst_rd_data", bus.rd_data, 32'd0);
        check("rst_sweep_done", 32'(sweep_done), 32'd0);
        reset = 1'b0;
        verify_reads("rst");

        // Fixed pattern ch*16+word, then randomized sweeps.
        run_sweep(0, -1, 0, r1, r0);
        check("s1_ch0_starts", 32'(r0), 32'd1);
        verify_reads("s1");
        for (int k = 2; k <= 4; k++) begin
            scramble_words();
            run_sweep(0, -1, 0, r1, r0);
            verify_reads($sformatf("s%0d", k));
        end

        // Reads coincident with COMMIT return the previous sweep.
        scramble_words();
        run_sweep(0, 3, 0, r1, r0);
        verify_reads("s5");
        scramble_words();
        run_sweep(0, 4 * $urandom_range(0, NUM_CH - 1) + $urandom_range(0, 2), 0, r1, r0);
        verify_reads("s6");

        // Two 10-cycle acks make the sweep longer than PERIOD, so the next tick is dropped.
        ack_delay = 10;
        scramble_words();
        run_sweep(1, -1, 0, r1, r0);
        m_ovr = 1'b1;
        check("ovr_single_sweep", 32'(r0), 32'd1);
        verify_reads("ovr");
        clear_errors();
        ack_delay = 2;

        // Reset in the middle of a channel read.
        enable = 1'b1;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (dbg_state == RD_TURNS) found = 1;
        end
        check("reach_rd_turns", 32'(found), 32'd1);
        reset = 1'b1;
        #1;
        check("midrst_snap_req", 32'(bus.snap_req), 32'd0);
        check("midrst_state", 32'(dbg_state), 32'(IDLE));
        check("midrst_seq", 32'(seq_num), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        enable = 1'b0;
        model_reset();
        exp_done = done_cnt;
        verify_reads("midrst");
        scramble_words();
        run_sweep(0, -1, 0, r1, r0);
        verify_reads("postrst");

        // Channel 1 never acks: request lasts the REQ cycle plus TIMEOUT waiting cycles;
        // err_clr lands on the same edge as the flag being set.
        never_ack[1] = 1'b1;
        scramble_words();
        run_sweep(0, -1, 1, r1, r0);
        check("to_req_cycles", 32'(r1), 32'(TIMEOUT + 1));
        verify_reads("to");
        clear_errors();
        never_ack[1] = 1'b0;

        // Sequence wrap from a forced starting point.
        force dut.seq_num = 16'hFFFE;
        release dut.seq_num;
        m_seq = 16'hFFFE;
        @(negedge clk);
        check("wrap_forced", 32'(seq_num), 32'h0000FFFE);
        for (int k = 0; k < 2; k++) begin
            scramble_words();
            run_sweep(0, -1, 0, r1, r0);
            verify_reads($sformatf("wrap%0d", k));
        end
        check("wrap_zero", 32'(seq_num), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
